// File: rtl/led_pio_pkg.sv
// led_pio_pkg
// Shared constants for the LED pulse PIO slice: Avalon-MM word addresses of
// the register map and the width of the pulse duration register.
// No ports; imported by led_pulse_pio and led_pulse_timer.
package led_pio_pkg;

    // Register map word addresses
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RSVD     = 3'd1;
    localparam logic [2:0] ADDR_DURATION = 3'd2;
    localparam logic [2:0] ADDR_TRIGGER  = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    // Pulse duration register width, in prescaler ticks
    localparam int DURATION_W = 16;

endpackage

// File: rtl/led_pulse_timer.sv
// led_pulse_timer
// One per-LED pulse timer: a down counter plus busy flag. A load with a
// non-zero duration (re)starts the pulse; each shared tick decrements a running
// counter and the 1->0 step ends the pulse on the same edge.
// Ports:
//   clk       - clock
//   reset_n   - asynchronous active-low reset
//   tick      - one-cycle prescaler tick shared by all timers
//   load      - trigger request for this bit
//   duration  - reload value (ticks); zero means the trigger is ignored
//   busy      - high while the pulse is running
module led_pulse_timer
    import led_pio_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  load,
    input  logic [DURATION_W-1:0] duration,
    output logic                  busy
);

    logic [DURATION_W-1:0] cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    // Load takes priority over a coinciding tick, and reloads rather than
    // accumulating so a retrigger restarts the full duration.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (load && (duration != '0)) begin
            cnt_d  = duration;
            busy_d = 1'b1;
        end else if (tick && busy_q) begin
            cnt_d = cnt_q - DURATION_W'(1);
            if (cnt_q == DURATION_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/led_pulse_pio.sv
// led_pulse_pio
// Avalon-MM LED output port with optional per-bit timed pulses. The LED
// output is the data register OR'd with the per-bit pulse busy flags.
// Build option: define LED_PULSE_PIO_PULSE_EN to include the pulse engine
// (prescaler, timers, duration and trigger registers). Without it, addresses
// 2/3 read 0, writes to them are dropped and out_port follows data only.
// Ports:
//   clk        - single clock
//   reset_n    - asynchronous active-low reset
//   address    - word address (3 bits)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - 32-bit write data
//   readdata   - registered read data, 1-cycle latency, chipselect-independent
//   out_port   - registered LED drive, WIDTH bits
module led_pulse_pio
    import led_pio_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          PRESCALE    = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr_en;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] busy;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] out_port_q, out_port_d;
    logic             unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign wr_bits      = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

`ifdef LED_PULSE_PIO_PULSE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]       prescale_q, prescale_d;
    logic                  tick;
    logic [DURATION_W-1:0] duration_q, duration_d;
    logic [WIDTH-1:0]      trigger;

    // Free-running prescaler; tick marks the wrap cycle so the timers step
    // on the same edge the prescaler returns to 0.
    always_comb begin
        tick       = (prescale_q == PS_W'(PRESCALE - 1));
        prescale_d = tick ? '0 : prescale_q + PS_W'(1);
        duration_d = duration_q;
        if (wr_en && (address == ADDR_DURATION)) begin
            duration_d = writedata[DURATION_W-1:0];
        end
        trigger = (wr_en && (address == ADDR_TRIGGER)) ? wr_bits : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q <= '0;
            duration_q <= '0;
        end else begin
            prescale_q <= prescale_d;
            duration_q <= duration_d;
        end
    end

    // Timers sample duration_q only on load, so rewriting duration leaves
    // running pulses alone.
    for (genvar i = 0; i < WIDTH; i++) begin : g_timer
        led_pulse_timer u_timer (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick     (tick),
            .load     (trigger[i]),
            .duration (duration_q),
            .busy     (busy[i])
        );
    end
`else
    assign busy = '0;
`endif

    // Data register: direct write, plus bitwise set/clear aliases.
    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d = wr_bits;
                ADDR_OUTSET:   data_d = data_q | wr_bits;
                ADDR_OUTCLEAR: data_d = data_q & ~wr_bits;
                default:       data_d = data_q;
            endcase
        end
    end

    // Read mux is registered every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d = 32'(data_q);
`ifdef LED_PULSE_PIO_PULSE_EN
            ADDR_DURATION: readdata_d = 32'(duration_q);
            ADDR_TRIGGER:  readdata_d = 32'(busy);
`endif
            default:       readdata_d = '0;
        endcase
        out_port_d = data_q | busy;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE[WIDTH-1:0];
            readdata_q <= '0;
            out_port_q <= RESET_VALUE[WIDTH-1:0];
        end else begin
            data_q     <= data_d;
            readdata_q <= readdata_d;
            out_port_q <= out_port_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_port_q;

endmodule

// File: tb/tb_led_pulse_pio.sv
// tb_led_pulse_pio
// Directed bench for led_pulse_pio with WIDTH=4, PRESCALE=4, RESET_VALUE=5.
// Exercises the pulse engine when LED_PULSE_PIO_PULSE_EN is defined and the
// disabled-engine behaviour otherwise.
module tb_led_pulse_pio;
    import led_pio_pkg::*;

    localparam int          WIDTH       = 4;
    localparam int          PRESCALE    = 4;
    localparam logic [31:0] RESET_VALUE = 32'h5;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic [2:0]       address    = '0;
    logic             chipselect = 1'b0;
    logic             write_n    = 1'b1;
    logic [31:0]      writedata  = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int          checkCount = 0;
    int          passCount  = 0;
    int          failCount  = 0;
    logic [31:0] expQ[$];
    int          pulseLen;
    int          endLen;

    always #5 clk = ~clk;

    led_pulse_pio #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .PRESCALE    (PRESCALE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    // Advance to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one bus cycle, optionally a write, then return the bus to idle
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] wdata, input bit doWrite);
        address    = addr;
        writedata  = wdata;
        chipselect = doWrite;
        write_n    = !doWrite;
        nextCycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
        checkCount++;
        assert (observed >= lo && observed <= hi) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
        end
    endtask

    // Read through the scoreboard: expectation queued at issue, compared
    // when the registered read data appears one cycle later.
    task automatic readReg(input string tag, input logic [2:0] addr, input logic [31:0] expected);
        logic [31:0] exp;
        expQ.push_back(expected);
        applyStimulus(addr, 32'h0, 1'b0);
        exp = expQ.pop_front();
        checkOutput(tag, readdata, exp);
    endtask

    initial begin
        $display("[TB] start");
        reset_n = 1'b0;
        repeat (3) nextCycle();
        checkOutput("reset_out_port", 32'(out_port), 32'h5);
        checkOutput("reset_readdata", readdata, 32'h0);
        reset_n = 1'b1;

        readReg("read_data_after_reset", ADDR_DATA, 32'h5);
        readReg("read_reserved1", ADDR_RSVD, 32'h0);

        // Upper writedata bits must be discarded
        applyStimulus(ADDR_DATA, 32'hFFFF_FFFA, 1'b1);
        applyStimulus(ADDR_OUTSET, 32'hFFFF_0001, 1'b1);
        applyStimulus(ADDR_OUTCLEAR, 32'h0000_0008, 1'b1);
        readReg("data_after_set_clear", ADDR_DATA, 32'h3);
        checkOutput("out_port_after_set_clear", 32'(out_port), 32'h3);

        for (int a = 4; a < 8; a++) begin
            readReg($sformatf("read_addr%0d", a), 3'(a), 32'h0);
        end

`ifdef LED_PULSE_PIO_PULSE_EN
        $display("[TB] pulse engine enabled");
        applyStimulus(ADDR_DATA, 32'h0, 1'b1);
        applyStimulus(ADDR_DURATION, 32'hFFFF_0003, 1'b1);
        readReg("read_duration", ADDR_DURATION, 32'h3);

        // Duration 3 pulse on bit 1
        applyStimulus(ADDR_TRIGGER, 32'h2, 1'b1);
        readReg("busy_after_trigger", ADDR_TRIGGER, 32'h2);
        pulseLen = out_port[1] ? 1 : 0;
        for (int i = 0; i < 40 && out_port[1]; i++) begin
            nextCycle();
            if (out_port[1]) pulseLen++;
        end
        checkRange("pulse_len_dur3", pulseLen, 9, 12);
        readReg("busy_after_pulse", ADDR_TRIGGER, 32'h0);
        checkOutput("out_port_after_pulse", 32'(out_port), 32'h0);

        // Zero duration makes triggers no-ops
        applyStimulus(ADDR_DURATION, 32'h0, 1'b1);
        applyStimulus(ADDR_TRIGGER, 32'hF, 1'b1);
        readReg("busy_dur0", ADDR_TRIGGER, 32'h0);
        repeat (8) nextCycle();
        checkOutput("out_port_dur0", 32'(out_port), 32'h0);
        readReg("busy_dur0_later", ADDR_TRIGGER, 32'h0);

        // Retrigger restarts rather than extends
        applyStimulus(ADDR_DURATION, 32'h2, 1'b1);
        applyStimulus(ADDR_TRIGGER, 32'h1, 1'b1);
        repeat (5) nextCycle();
        applyStimulus(ADDR_TRIGGER, 32'h1, 1'b1);
        endLen = 0;
        for (int i = 0; i < 40; i++) begin
            nextCycle();
            endLen++;
            if (!out_port[0]) break;
        end
        checkRange("retrigger_end", endLen - 1, 5, 8);

        // Reset in the middle of a pulse aborts it
        applyStimulus(ADDR_TRIGGER, 32'h1, 1'b1);
        repeat (2) nextCycle();
        checkOutput("out_port_mid_pulse", 32'(out_port), 32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_out_port", 32'(out_port), 32'h5);
        checkOutput("midreset_readdata", readdata, 32'h0);
        nextCycle();
        reset_n = 1'b1;
        readReg("busy_after_midreset", ADDR_TRIGGER, 32'h0);
        readReg("duration_after_midreset", ADDR_DURATION, 32'h0);
        repeat (12) nextCycle();
        checkOutput("no_pulse_resumes", 32'(out_port), 32'h5);
`else
        $display("[TB] pulse engine disabled");
        applyStimulus(ADDR_DURATION, 32'h7, 1'b1);
        applyStimulus(ADDR_TRIGGER, 32'hF, 1'b1);
        readReg("disabled_read_addr2", ADDR_DURATION, 32'h0);
        readReg("disabled_read_addr3", ADDR_TRIGGER, 32'h0);
        repeat (8) nextCycle();
        checkOutput("disabled_out_port_eq_data", 32'(out_port), 32'h3);

        reset_n = 1'b0;
        #1;
        checkOutput("midreset_out_port", 32'(out_port), 32'h5);
        checkOutput("midreset_readdata", readdata, 32'h0);
        nextCycle();
        reset_n = 1'b1;
        readReg("data_after_midreset", ADDR_DATA, 32'h5);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/led_pulse_pio.md
LED_PULSE_PIO -- requirements
Module: led_pulse_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of output bits (1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, giving the data register value after reset.
REQ-003 The block SHALL have parameter PRESCALE, default 50000, giving clk cycles per pulse tick (>=1).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port address, input, 3 bits: Avalon-MM word address.
REQ-007 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-008 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-009 The block SHALL have port writedata, input, 32 bits: write data.
REQ-010 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 The block SHALL have port out_port, output, WIDTH bits: LED drive.

Function
REQ-012 A write SHALL occur on a cycle with chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used, except at address 2 where writedata[15:0] is used.
REQ-013 Register map SHALL be: 0 data (R/W), 1 reserved (reads 0), 2 duration (R/W, 16 bits, ticks), 3 trigger (W) / busy mask (R), 4 outset (W, reads 0), 5 outclear (W, reads 0), 6-7 reserved (reads 0).
REQ-014 readdata SHALL be registered every cycle from the current address, independent of chipselect; read latency is exactly 1 cycle; unused upper bits read 0.
REQ-015 A write to outset SHALL set data bits where writedata is 1; a write to outclear SHALL clear them; other bits are unchanged.
REQ-016 The prescaler SHALL count 0..PRESCALE-1 continuously and assert a one-cycle tick when it wraps.
REQ-017 A trigger write with bit i =1 and duration !=0 SHALL load cnt[i] with duration and set busy[i] on the next edge; if duration = 0, the trigger SHALL be ignored.
REQ-018 A trigger while busy[i] =1 SHALL reload cnt[i] (retrigger); it SHALL NOT extend by accumulation.
REQ-019 On each tick, every busy counter SHALL decrement; a counter decrementing from 1 to 0 SHALL clear busy[i] on the same edge.
REQ-020 Pulse length SHALL be between (duration-1)*PRESCALE+1 and duration*PRESCALE cycles.
REQ-021 If a trigger and a tick coincide for a bit, the load SHALL win.
REQ-022 out_port SHALL be registered: out_port[i] = data[i] | busy[i], updated one cycle after the register or busy change.
REQ-023 A duration write SHALL NOT affect counters already running.

Reset
REQ-024 On reset_n=0, the following SHALL apply: data=RESET_VALUE, duration=0, busy=0, all counters and prescaler=0, readdata=0, out_port=RESET_VALUE[WIDTH-1:0].
REQ-025 Reset asserted mid-pulse SHALL immediately abort the pulse; no pulse resumes after release.

Configuration
REQ-026 Macro LED_PULSE_PIO_PULSE_EN defined: the pulse engine (prescaler, counters, addresses 2/3) SHALL be present as specified.
REQ-027 Macro LED_PULSE_PIO_PULSE_EN undefined: addresses 2/3 SHALL read 0, writes to them SHALL be ignored, busy SHALL be constant 0, and out_port SHALL equal data.

Structure
REQ-028 The shared package led_pio_pkg SHALL hold the address constants (ADDR_DATA..ADDR_OUTCLEAR) and the 16-bit duration width constant.
REQ-029 The per-bit counter and busy logic SHALL be a sub-module led_pulse_timer, instantiated WIDTH times with a shared tick.

Verification (PRESCALE=4, WIDTH=4)
REQ-030 Bench SHALL check: reset with RESET_VALUE=4'h5 -> out_port=4'h5 and readdata=0; then read addr 0 -> 5 one cycle later.
REQ-031 Bench SHALL check: write data=4'hA, outset 4'h1, outclear 4'h8 -> data reads 4'h3 and out_port=4'h3.
REQ-032 Bench SHALL check: duration=3, trigger 4'h2 -> busy reads 4'h2, out_port[1]=1 for 9..12 cycles, then busy reads 0.
REQ-033 Bench SHALL check: duration=0, trigger 4'hF -> busy stays 0 and out_port is unchanged.
REQ-034 Bench SHALL check: retrigger bit 0 with duration=2 after 5 cycles of a duration-2 pulse -> pulse ends 5..8 cycles after the retrigger; reset_n pulsed mid-pulse -> busy=0 immediately.
REQ-035 Bench SHALL check: with the macro undefined, write addr 2 = 7 and trigger 4'hF -> reads of addr 2/3 return 0 and out_port=data.
